seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand width; result width is 2*WIDTH.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 clear  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  numerator (A), sampled on the accepted start edge.
REQ-006 divisor  input  WIDTH  denominator (B), sampled on the accepted start edge.
REQ-007 signed_op  input  1  1 = two's-complement division, 0 = unsigned; sampled with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 div_by_zero  output  1  flag for the completed operation, valid with done and held until the next accepted start.
REQ-011 result  output  2*WIDTH  [WIDTH-1:0] = quotient, [2*WIDTH-1:WIDTH] = remainder; layout matches the ALU div_result low/high split.

Function
REQ-012 Restoring shift-subtract algorithm, one quotient bit per clock, on operand magnitudes.
REQ-013 States: IDLE, CALC, FIX, DONE; state register holds exactly one of these.
REQ-014 IDLE -> CALC on the rising edge where start=1: latch operands, load the iteration counter with WIDTH, clear the partial remainder.
REQ-015 CALC: one iteration per cycle; counter decrements; CALC -> FIX after exactly WIDTH cycles (counter reaches 0).
REQ-016 FIX: apply sign correction and the divide-by-zero override, then register result; FIX -> DONE unconditionally.
REQ-017 DONE: done=1 for exactly this one cycle; DONE -> IDLE unconditionally.
REQ-018 Latency: done is high in the cycle after the (WIDTH+2)th rising edge following the start edge (34 edges for WIDTH=32); latency is fixed and independent of data.
REQ-019 start while busy=1 is ignored and has no effect on the operation in flight.
REQ-020 result and div_by_zero hold their values from DONE until FIX of the next operation.
REQ-021 Signed rules: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF) gives quotient 0x80000000 and remainder 0; div_by_zero=0.
REQ-023 divisor=0: quotient all-ones, remainder = dividend unmodified, div_by_zero=1; the latency is still WIDTH+2.
REQ-024 A start in the DONE cycle is ignored; a start is accepted one cycle later in IDLE.

Reset
REQ-025 clear=1 at a rising edge forces IDLE, busy=0, done=0, div_by_zero=0, result=0, counter=0, with precedence over start.
REQ-026 If clear is asserted mid-operation (CALC or FIX), the operation is aborted silently and no done pulse is produced.

Configuration
REQ-027 Macro SEQ_DIVIDER_SIGNED_EN defined: signed_op honoured per REQ-021/022, using magnitude conversion on entry and negation in FIX.
REQ-028 Macro SEQ_DIVIDER_SIGNED_EN undefined: signed_op input is present but ignored; all operations are unsigned; no sign-correction logic is synthesised.

Structure
REQ-029 Shared package div_pkg holds the state enum (IDLE, CALC, FIX, DONE), the DIV_WIDTH=32 constant and the iteration-count constant.
REQ-030 One sub-module, div_step: a combinational single iteration (shift remainder, trial subtract, quotient bit); seq_divider instantiates it once.
REQ-031 There are no latches; every output is driven from registers.

Verification
REQ-032 100/7 unsigned -> done after 34 edges, result=0x00000002_0000000E, div_by_zero=0.
REQ-033 SIGNED_EN, signed_op=1, 0xFFFFFFF9/2 (-7/2) -> result=0xFFFFFFFF_FFFFFFFD; without the macro, the same operands -> 0x00000001_7FFFFFFC.
REQ-034 5/0 -> result=0x00000005_FFFFFFFF, div_by_zero=1, done at edge 34.
REQ-035 SIGNED_EN, 0x80000000/0xFFFFFFFF signed -> result=0x00000000_80000000, div_by_zero=0.
REQ-036 Start 100/7, pulse start again with 9/3 at edge 5 -> the second start is ignored and the result is 0x00000002_0000000E.
REQ-037 Start 100/7, clear at edge 10 -> busy=0 next cycle, result=0, no done pulse; a new start of 9/3 then completes with 0x00000000_00000003.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH  = 32;
    localparam int unsigned ITER_COUNT = DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and emit one quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             fits;

    // The shifted remainder needs one extra bit; after a successful subtract it fits in WIDTH again.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor});
        trial   = WIDTH'(shifted - {1'b0, divisor});
        rem_out = fits ? trial : shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, fixed latency.
// Define SEQ_DIVIDER_SIGNED_EN to honour signed_op (two's-complement division).
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic                 signed_op,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    div_state_e       state;
    div_state_e       state_next;
    logic             load;
    logic             iterate;
    logic             finish;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] den_q;
    logic [WIDTH-1:0] num_raw_q;
    logic             zero_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (den_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic q_neg_q;
    logic r_neg_q;

    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
    assign a_mag = a_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign b_mag = b_neg ? (~divisor + WIDTH'(1)) : divisor;

    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    always_ff @(posedge clock) begin
        if (clear) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (load) begin
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
        end
    end

    assign fix_quo = q_neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
    assign fix_rem = r_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign a_mag            = dividend;
    assign b_mag            = divisor;
    assign fix_quo          = quo_q;
    assign fix_rem          = rem_q;
`endif

    // State register plus registered status outputs decoded from the next state.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        iterate    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                iterate = 1'b1;
                if (count == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                finish     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, iteration datapath and result register.
    always_ff @(posedge clock) begin
        if (clear) begin
            count       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            den_q       <= '0;
            num_raw_q   <= '0;
            zero_q      <= 1'b0;
            div_by_zero <= 1'b0;
            result      <= '0;
        end else begin
            if (load) begin
                count     <= CNT_W'(WIDTH);
                quo_q     <= a_mag;
                rem_q     <= '0;
                den_q     <= b_mag;
                num_raw_q <= dividend;
                zero_q    <= (divisor == '0);
            end else if (iterate) begin
                count <= count - CNT_W'(1);
                quo_q <= step_quo;
                rem_q <= step_rem;
            end

            // Divide-by-zero reports the dividend as given, bypassing sign correction.
            if (finish) begin
                div_by_zero <= zero_q;
                if (zero_q) begin
                    result <= {num_raw_q, {WIDTH{1'b1}}};
                end else begin
                    result <= {fix_rem, fix_quo};
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// operands checked against an arithmetic reference model.
module tb_seq_divider;
    import div_pkg::*;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    localparam int LATENCY = ITER_COUNT + 2;
    localparam int TIMEOUT = 200;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        signed_op;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    seq_divider #(
        .WIDTH       (DIV_WIDTH)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .signed_op   (signed_op),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain integer division; SV '/' and '%' truncate toward zero.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic   use_signed;
        use_signed = s && SIGNED_EN;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (use_signed) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start; returns at the falling edge after the start edge.
    task automatic start_pulse(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clock);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Count rising edges (start edge = 1) until done is seen, bounded by TIMEOUT.
    task automatic wait_done(input int from, output int edges);
        edges = from;
        while (done !== 1'b1 && edges < TIMEOUT) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp_r, input logic exp_z, input string tag);
        int edges;
        start_pulse(a, b, s);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(1, edges);
        check({tag, "_lat"}, 64'(edges), 64'(LATENCY));
        check({tag, "_res"}, result, exp_r);
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_z));
        @(posedge clock);
        @(negedge clock);
        check({tag, "_idle"}, 64'({busy, done}), 64'd0);
        check({tag, "_hold"}, result, exp_r);
    endtask

    initial begin
        int          edges;
        int          pulses;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;

        clear     = 1'b1;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        signed_op = 1'b0;

        // Reset, with start asserted to confirm clear has precedence.
        repeat (2) @(posedge clock);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("reset_flags", 64'({busy, done, div_by_zero}), 64'd0);
        check("reset_result", result, 64'd0);
        start = 1'b0;
        clear = 1'b0;

        run_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1'b0, "u100_7");
        run_op(32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF, 1'b1, "div0");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1,
               SIGNED_EN ? 64'hFFFFFFFF_FFFFFFFD : 64'h00000001_7FFFFFFC, 1'b0, "neg7_2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
               SIGNED_EN ? 64'h00000000_80000000 : 64'h80000000_00000000, 1'b0, "ovf");
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 64'hFFFFFFF9_FFFFFFFF, 1'b1, "neg_div0");

        // Second start while busy must not disturb the operation in flight.
        start_pulse(32'd100, 32'd7, 1'b0);
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
        end
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        wait_done(5, edges);
        check("busy_start_lat", 64'(edges), 64'(LATENCY));
        check("busy_start_res", result, 64'h00000002_0000000E);

        // Start during the DONE cycle is ignored; held start is taken the next cycle.
        @(posedge clock);
        @(negedge clock);
        start_pulse(32'd1000, 32'd10, 1'b0);
        wait_done(1, edges);
        check("dcyc_first", result, 64'h00000000_00000064);
        dividend = 32'd77;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("dcyc_ignored", 64'(busy), 64'd0);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("dcyc_accept", 64'(busy), 64'd1);
        wait_done(1, edges);
        check("dcyc_lat", 64'(edges), 64'(LATENCY));
        check("dcyc_res", result, 64'h00000002_0000000F);

        // Clear at edge 10 aborts silently.
        @(posedge clock);
        @(negedge clock);
        start_pulse(32'd100, 32'd7, 1'b0);
        repeat (8) begin
            @(posedge clock);
            @(negedge clock);
        end
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        check("abort_flags", 64'({busy, done, div_by_zero}), 64'd0);
        check("abort_result", result, 64'd0);
        pulses = 0;
        repeat (LATENCY + 6) begin
            @(posedge clock);
            @(negedge clock);
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        run_op(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 1'b0, "after_abort");

        // Random operands against the reference model.
        for (int i = 0; i < 24; i++) begin
            a = 32'($urandom());
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom());
                1:       b = 32'($urandom_range(1, 255));
                2:       b = (i % 5 == 0) ? 32'd0 : 32'($urandom_range(1, 15));
                default: b = 32'd0 - 32'($urandom_range(1, 100));
            endcase
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, ref_div(a, b, s), (b == 32'd0), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
